// File: rtl/wbs_rx_fifo.sv
// Wishbone slave RX FIFO: buffers 16-bit producer words for host readout via the
// DATA register, with status, count, threshold, drop-counter and a level interrupt.
module wbs_rx_fifo #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] wb_dat_i,
  input  logic [4:0]  wb_adr_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        int_out
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_COUNT  = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_THRESH = 3'd4;
  localparam logic [2:0] REG_DROPS  = 3'd5;

  logic [DEPTH_LOG2-1:0] wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]         count, count_nxt, thresh;
  logic [15:0]           mem [DEPTH];
  logic [15:0]           ram_q, byp_dat, head, rdata, drops, dat_q;
  logic                  byp_sel, ovf, unf, int_en, full_n_q, ack_q, int_q;
  logic [2:0]            idx;
  logic                  acc, rd_acc, wr_acc, empty, full;
  logic                  flush, push, pop, unf_ev, drop_ev, w1c_ovf, w1c_unf;
  logic                  unused_ok;

  assign unused_ok = ^{wb_cti_i, wb_adr_i[4], wb_adr_i[0], wb_dat_i};

  assign idx    = wb_adr_i[3:1];
  assign acc    = wb_cyc_i & wb_stb_i & ~ack_q;
  assign rd_acc = acc & ~wb_we_i;
  assign wr_acc = acc & wb_we_i;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  assign flush   = wr_acc & (idx == REG_CTRL) & wb_sel_i[0] & wb_dat_i[0];
  assign w1c_ovf = wr_acc & (idx == REG_STATUS) & wb_sel_i[0] & wb_dat_i[2];
  assign w1c_unf = wr_acc & (idx == REG_STATUS) & wb_sel_i[0] & wb_dat_i[3];
  assign pop     = rd_acc & (idx == REG_DATA) & ~empty;
  assign unf_ev  = rd_acc & (idx == REG_DATA) & empty;

  // The ready flop resets high; gating with reset keeps din_ready low only
  // while reset is asserted.
  assign din_ready = full_n_q & ~wb_rst_i;
  assign push      = din_valid & din_ready & ~flush;
  assign drop_ev   = din_valid & ~din_ready & ~wb_rst_i;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push) wr_ptr_nxt = wr_ptr + 1'b1;
      if (pop)  rd_ptr_nxt = rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_nxt = count + 1'b1;
        2'b01:   count_nxt = count - 1'b1;
        default: count_nxt = count;
      endcase
    end
  end

  // Block RAM with a registered read of the next head address; a word written
  // to that same address in the same cycle is taken from the bypass register.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= din;
    ram_q   <= mem[rd_ptr_nxt];
    byp_dat <= din;
  end

  assign head = byp_sel ? byp_dat : ram_q;

  always_comb begin
    rdata = '0;
    case (idx)
      REG_DATA:   rdata = empty ? 16'h0000 : head;
      REG_STATUS: rdata = {12'h000, unf, ovf, full, empty};
      REG_COUNT:  rdata = {{(16-CW){1'b0}}, count};
      REG_CTRL:   rdata = {14'h0000, int_en, 1'b0};
      REG_THRESH: rdata = {{(16-CW){1'b0}}, thresh};
      REG_DROPS:  rdata = drops;
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      byp_sel  <= 1'b0;
      full_n_q <= 1'b1;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      drops    <= '0;
      thresh   <= '0;
      int_en   <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      int_q    <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      byp_sel  <= push & (wr_ptr == rd_ptr_nxt);
      full_n_q <= (count_nxt != CW'(DEPTH));

      // Event set wins over a coincident clear so no event is lost.
      if (w1c_ovf) ovf <= 1'b0;
      if (drop_ev) ovf <= 1'b1;
      if (w1c_unf) unf <= 1'b0;
      if (unf_ev)  unf <= 1'b1;

      if (drop_ev && drops != 16'hFFFF) drops <= drops + 1'b1;

      if (wr_acc && idx == REG_THRESH) begin
        if (wb_sel_i[0]) thresh[7:0]    <= wb_dat_i[7:0];
        if (wb_sel_i[1]) thresh[CW-1:8] <= wb_dat_i[CW-1:8];
      end
      if (wr_acc && idx == REG_CTRL && wb_sel_i[0]) int_en <= wb_dat_i[1];

      ack_q <= acc;
      dat_q <= rd_acc ? rdata : 16'h0000;
      int_q <= int_en & (thresh != '0) & (count >= thresh);
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;
  assign int_out  = int_q;

endmodule
